// File: rtl/aes_mem_pkg.sv
// Shared definitions for the AES buffer memories: clear-engine state
// encoding, default geometry and a small address range helper.
package aes_mem_pkg;

  // Clear engine states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Default word width and depth of an AES byte buffer.
  localparam int AES_BYTE_W    = 8;
  localparam int AES_BUF_DEPTH = 64;

  // Bytes per AES block; instantiators use this to size buffers.
  localparam int AES_BLOCK_BYTES = 16;

  // True when an address falls inside an array of 'depth' words.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/aes_ram_clr_seq.sv
// Sequential clear engine: once started it walks the address counter from
// 0 to DEPTH-1, asserting a write enable every cycle, then drops busy and
// pulses clr_done. A new request while clearing is ignored.
module aes_ram_clr_seq
  import aes_mem_pkg::*;
#(
  parameter int DEPTH  = AES_BUF_DEPTH,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_rq_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output clr_state_e        state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  // State, counter and completion pulse registers; reset aborts a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: the edge that writes the last word returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_rq_i) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;
  assign clr_done_o = done_q;
  assign state_o    = state_q;

endmodule

// File: rtl/aes_ram_sync_dp.sv
// Dual-port (one write, one read) synchronous RAM for AES key/state
// buffers. Reads are registered with a one-cycle valid strobe and see a
// same-cycle write to the same address (write-first). A sequential clear
// engine wipes the array to CLR_VAL; user requests are refused meanwhile.
//
// Handshake: a request is accepted in any cycle where its *_rq is high and
// busy is low; there is no ready/stall, a refused request is simply dropped
// and flagged by a one-cycle req_drop pulse on the following cycle.
module aes_ram_sync_dp
  import aes_mem_pkg::*;
#(
  parameter int                DATA_W  = AES_BYTE_W,
  parameter int                DEPTH   = AES_BUF_DEPTH,
  parameter int                ADDR_W  = 6,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_rq,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_rq,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_rq,
  output logic              busy,
  output logic              clr_done,
  output logic              req_drop,
  output logic              addr_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              req_drop_q, req_drop_d;
  logic              addr_err_q, addr_err_d;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  clr_state_e        clr_state;

  logic              wr_in_range, rd_in_range;
  logic              wr_acc, rd_acc, wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  aes_ram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_rq_i   (clr_rq),
    .busy_o     (busy),
    .clr_done_o (clr_done),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .state_o    (clr_state)
  );

  assign wr_in_range = addr_in_range(32'(wr_addr), 32'(DEPTH));
  assign rd_in_range = addr_in_range(32'(rd_addr), 32'(DEPTH));
  assign wr_acc      = wr_rq && !busy;
  assign rd_acc      = rd_rq && !busy;
  assign wr_ok       = wr_acc && wr_in_range;

  // The clear engine owns the write port while busy; user writes only
  // reach the array when the engine is idle.
  assign mem_we    = clr_we || wr_ok;
  assign mem_waddr = clr_we ? clr_addr : wr_addr;
  assign mem_wdata = clr_we ? CLR_VAL  : wr_data;

  // Array storage: cleared to zero by reset, not to CLR_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read data mux with write-first bypass; out-of-range reads return zero.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      if (!rd_in_range) begin
        rd_data_d = '0;
      end else if (wr_ok && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_q[rd_addr];
      end
    end
    req_drop_d = busy && (wr_rq || rd_rq);
    addr_err_d = (wr_acc && !wr_in_range) || (rd_acc && !rd_in_range);
  end

  // Read register and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      req_drop_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      req_drop_q <= req_drop_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign req_drop = req_drop_q;
  assign addr_err = addr_err_q;

  // busy must always track the clear engine state.
  busy_tracks_state: assert property (@(posedge clk) disable iff (!rst)
    busy == (clr_state == CLEAR));

endmodule

// File: tb/tb_aes_ram_sync_dp.sv
// Directed bench for aes_ram_sync_dp. Three instances cover the default
// 64x8 buffer with CLR_VAL=0xFF, a 48-deep buffer for out-of-range
// addresses, and a 16x128 round-key store.
module tb_aes_ram_sync_dp;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  // ---------------- instance A: 64 x 8, CLR_VAL = 0xFF ----------------
  logic       a_wr_rq, a_rd_rq, a_clr_rq;
  logic [5:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_wr_data, a_rd_data;
  logic       a_rd_valid, a_busy, a_clr_done, a_req_drop, a_addr_err;

  aes_ram_sync_dp #(
    .DATA_W (8), .DEPTH (64), .ADDR_W (6), .CLR_VAL (8'hFF)
  ) u_dut_a (
    .clk (clk), .rst (rst),
    .wr_rq (a_wr_rq), .wr_addr (a_wr_addr), .wr_data (a_wr_data),
    .rd_rq (a_rd_rq), .rd_addr (a_rd_addr), .rd_data (a_rd_data),
    .rd_valid (a_rd_valid), .clr_rq (a_clr_rq), .busy (a_busy),
    .clr_done (a_clr_done), .req_drop (a_req_drop), .addr_err (a_addr_err)
  );

  // ---------------- instance B: 48 x 8 ----------------
  logic       b_wr_rq, b_rd_rq, b_clr_rq;
  logic [5:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data;
  logic       b_rd_valid, b_busy, b_clr_done, b_req_drop, b_addr_err;

  aes_ram_sync_dp #(
    .DATA_W (8), .DEPTH (48), .ADDR_W (6), .CLR_VAL (8'h00)
  ) u_dut_b (
    .clk (clk), .rst (rst),
    .wr_rq (b_wr_rq), .wr_addr (b_wr_addr), .wr_data (b_wr_data),
    .rd_rq (b_rd_rq), .rd_addr (b_rd_addr), .rd_data (b_rd_data),
    .rd_valid (b_rd_valid), .clr_rq (b_clr_rq), .busy (b_busy),
    .clr_done (b_clr_done), .req_drop (b_req_drop), .addr_err (b_addr_err)
  );

  // ---------------- instance C: 16 x 128 round keys ----------------
  logic         c_wr_rq, c_rd_rq, c_clr_rq;
  logic [3:0]   c_wr_addr, c_rd_addr;
  logic [127:0] c_wr_data, c_rd_data;
  logic         c_rd_valid, c_busy, c_clr_done, c_req_drop, c_addr_err;

  aes_ram_sync_dp #(
    .DATA_W (128), .DEPTH (16), .ADDR_W (4), .CLR_VAL (128'h0)
  ) u_dut_c (
    .clk (clk), .rst (rst),
    .wr_rq (c_wr_rq), .wr_addr (c_wr_addr), .wr_data (c_wr_data),
    .rd_rq (c_rd_rq), .rd_addr (c_rd_addr), .rd_data (c_rd_data),
    .rd_valid (c_rd_valid), .clr_rq (c_clr_rq), .busy (c_busy),
    .clr_done (c_clr_done), .req_drop (c_req_drop), .addr_err (c_addr_err)
  );

  // AES-128 key schedule of the FIPS-197 example key.
  localparam logic [127:0] RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam int RD_ORDER [11] = '{7, 2, 10, 0, 5, 9, 1, 3, 8, 4, 6};

  // ---------------- scoreboard ----------------
  logic [127:0] model_c [16];
  logic [127:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [5:0] addr, input logic [7:0] data);
    a_wr_rq = 1'b1; a_wr_addr = addr; a_wr_data = data;
    tick();
    a_wr_rq = 1'b0;
  endtask

  task automatic a_read(input logic [5:0] addr, input logic [7:0] exp,
                        input string tag);
    a_rd_rq = 1'b1; a_rd_addr = addr;
    tick();
    a_rd_rq = 1'b0;
    check({tag, "_valid"}, a_rd_valid, 1'b1);
    check({tag, "_data"}, a_rd_data, exp);
    check({tag, "_aerr"}, a_addr_err, 1'b0);
  endtask

  task automatic b_write(input logic [5:0] addr, input logic [7:0] data,
                         input logic exp_err, input string tag);
    b_wr_rq = 1'b1; b_wr_addr = addr; b_wr_data = data;
    tick();
    b_wr_rq = 1'b0;
    check({tag, "_aerr"}, b_addr_err, exp_err);
  endtask

  task automatic b_read(input logic [5:0] addr, input logic [7:0] exp,
                        input logic exp_err, input string tag);
    b_rd_rq = 1'b1; b_rd_addr = addr;
    tick();
    b_rd_rq = 1'b0;
    check({tag, "_valid"}, b_rd_valid, 1'b1);
    check({tag, "_data"}, b_rd_data, exp);
    check({tag, "_aerr"}, b_addr_err, exp_err);
  endtask

  task automatic c_write(input logic [3:0] addr, input logic [127:0] data);
    c_wr_rq = 1'b1; c_wr_addr = addr; c_wr_data = data;
    model_c[addr] = data;
    tick();
    c_wr_rq = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int done_seen;
    logic [3:0] waddr;
    logic [127:0] wdata;

    checks = 0; failures = 0;
    rst = 1'b0;
    a_wr_rq = 0; a_rd_rq = 0; a_clr_rq = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_data = 0;
    b_wr_rq = 0; b_rd_rq = 0; b_clr_rq = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_data = 0;
    c_wr_rq = 0; c_rd_rq = 0; c_clr_rq = 0; c_wr_addr = 0; c_rd_addr = 0; c_wr_data = 0;
    for (int i = 0; i < 16; i++) model_c[i] = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_rd_data", a_rd_data, 8'h00);
    check("rst_rd_valid", a_rd_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_clr_done", a_clr_done, 1'b0);
    check("rst_req_drop", a_req_drop, 1'b0);
    check("rst_addr_err", a_addr_err, 1'b0);
    rst = 1'b1;
    tick();
    check("post_rst_valid", a_rd_valid, 1'b0);
    check("post_rst_busy", a_busy, 1'b0);

    // Reads after reset return zero with one-cycle latency.
    a_read(6'd0, 8'h00, "rst_rd0");
    a_read(6'd31, 8'h00, "rst_rd31");
    a_read(6'd63, 8'h00, "rst_rd63");

    // Write then read; then same-cycle write/read bypass.
    a_write(6'd10, 8'hA5);
    a_read(6'd10, 8'hA5, "wr_rd10");
    tick();
    check("idle_valid", a_rd_valid, 1'b0);
    check("idle_hold", a_rd_data, 8'hA5);
    a_wr_rq = 1'b1; a_wr_addr = 6'd10; a_wr_data = 8'h3C;
    a_read(6'd10, 8'h3C, "bypass10");
    a_wr_rq = 1'b0;
    a_read(6'd10, 8'h3C, "after_bypass10");

    // Fill every word with addr ^ 0x5A.
    for (int i = 0; i < 64; i++) a_write(6'(i), 8'(i) ^ 8'h5A);
    a_read(6'd0, 8'h5A, "fill0");
    a_read(6'd63, 8'h65, "fill63");

    // Start clear together with a read: read sees pre-clear data.
    a_clr_rq = 1'b1; a_rd_rq = 1'b1; a_rd_addr = 6'd7;
    tick();
    a_clr_rq = 1'b0; a_rd_rq = 1'b0;
    check("clr_start_busy", a_busy, 1'b1);
    check("clr_pre_rd_valid", a_rd_valid, 1'b1);
    check("clr_pre_rd_data", a_rd_data, 8'h5D);

    n = 0; done_seen = 0;
    while (a_busy && n < 200) begin
      n++;
      a_wr_rq = (n == 3); a_wr_addr = 6'd5; a_wr_data = 8'h11;
      a_rd_rq = (n == 6); a_rd_addr = 6'd5;
      a_clr_rq = (n == 10);
      tick();
      a_wr_rq = 1'b0; a_rd_rq = 1'b0; a_clr_rq = 1'b0;
      if (n == 3) check("drop_wr", a_req_drop, 1'b1);
      if (n == 4) check("drop_clear", a_req_drop, 1'b0);
      if (n == 6) check("drop_rd", a_req_drop, 1'b1);
      if (n == 6) check("drop_rd_novalid", a_rd_valid, 1'b0);
      if (a_clr_done) done_seen++;
    end
    check("clr_cycles", n, 64);
    check("clr_end_busy", a_busy, 1'b0);
    check("clr_done_count", done_seen, 1);
    check("clr_done_now", a_clr_done, 1'b1);
    tick();
    check("clr_done_one_cycle", a_clr_done, 1'b0);
    for (int i = 0; i < 64; i++) a_read(6'(i), 8'hFF, $sformatf("clr_rd%0d", i));

    // Reset in the middle of a clear at cnt = 20.
    a_clr_rq = 1'b1;
    tick();
    a_clr_rq = 1'b0;
    check("mid_clr_busy", a_busy, 1'b1);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_done", a_clr_done, 1'b0);
    tick();
    check("mid_rst_done2", a_clr_done, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rel_busy", a_busy, 1'b0);
    check("mid_rel_done", a_clr_done, 1'b0);
    for (int i = 0; i < 64; i++) a_read(6'(i), 8'h00, $sformatf("rst_clr_rd%0d", i));

    // Instance B: out-of-range accesses with DEPTH = 48.
    b_write(6'd47, 8'h12, 1'b0, "b_wr47");
    b_write(6'd50, 8'h77, 1'b1, "b_wr50");
    tick();
    check("b_aerr_pulse", b_addr_err, 1'b0);
    b_read(6'd47, 8'h12, 1'b0, "b_rd47");
    b_read(6'd50, 8'h00, 1'b1, "b_rd50");
    b_read(6'd2, 8'h00, 1'b0, "b_rd2");
    b_read(6'd18, 8'h00, 1'b0, "b_rd18");

    // Instance C: round keys, shuffled reads with concurrent writes.
    for (int i = 0; i < 11; i++) c_write(4'(i), RK[i]);
    for (int k = 0; k < 11; k++) begin
      c_rd_rq = 1'b1; c_rd_addr = 4'(RD_ORDER[k]);
      exp_q.push_back(model_c[RD_ORDER[k]]);
      c_wr_rq = (k % 2 == 1);
      if (c_wr_rq) begin
        waddr = 4'(11 + k / 2);
        wdata = ~RK[k];
        c_wr_addr = waddr; c_wr_data = wdata;
        model_c[waddr] = wdata;
      end
      tick();
      c_wr_rq = 1'b0;
      check($sformatf("c_rk_valid%0d", k), c_rd_valid, 1'b1);
      if (exp_q.size() > 0)
        check($sformatf("c_rk_data%0d", k), c_rd_data, exp_q.pop_front());
      else
        check("c_sb_empty", exp_q.size(), 1);
    end
    for (int a = 11; a < 16; a++) begin
      c_rd_rq = 1'b1; c_rd_addr = 4'(a);
      exp_q.push_back(model_c[a]);
      tick();
      check($sformatf("c_hi_valid%0d", a), c_rd_valid, 1'b1);
      if (exp_q.size() > 0)
        check($sformatf("c_hi_data%0d", a), c_rd_data, exp_q.pop_front());
      else
        check("c_sb_empty", exp_q.size(), 1);
    end
    c_rd_rq = 1'b0;
    tick();
    check("c_idle_valid", c_rd_valid, 1'b0);
    check("c_addr_err", c_addr_err, 1'b0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_ram_sync_dp.md
Name: aes_ram_sync_dp

Overview:
- Parametrised successor to the team's 64x8 single-port sync RAM.
- Separate write and read ports, so a write and a read can both complete in the same cycle.
- Registered read data with a one-cycle valid strobe, and write-first bypass when a read and a write hit the same address.
- A sequential clear engine so the AES key/state buffers can be wiped between blocks without a global reset.

Parameters:
DATA_W, 8, word width in bits
DEPTH, 64, number of words; legal range 2 .. 2**ADDR_W
ADDR_W, 6, address width in bits
CLR_VAL, 0, DATA_W-bit value written to every word by the clear engine

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
wr_rq  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_rq  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  registered read data
rd_valid  output  1  one-cycle strobe: rd_data updated this cycle
clr_rq  input  1  start sequential clear
busy  output  1  clear engine active; wr/rd requests refused
clr_done  output  1  one-cycle pulse at clear completion
req_drop  output  1  one-cycle pulse: a wr_rq or rd_rq was refused while busy
addr_err  output  1  one-cycle pulse: an accepted access used an address >= DEPTH

Behaviour:
- Reset (rst=0, asynchronous):
  - every word = 0 (not CLR_VAL);
  - rd_data=0, rd_valid=0, busy=0, clr_done=0, req_drop=0, addr_err=0;
  - FSM = IDLE, clear counter = 0.
- Reset asserted mid-clear: aborts the clear immediately and leaves the full reset state; no clr_done pulse.
- FSM states: IDLE, CLEAR.
- IDLE:
  - clr_rq=1 -> CLEAR at the next edge; busy rises that edge.
  - Requests presented in the same cycle as clr_rq are still accepted, because busy=0 that cycle.
- CLEAR:
  - writes CLR_VAL to mem[cnt] each cycle; cnt runs 0..DEPTH-1, so the clear takes exactly DEPTH cycles.
  - On the edge that writes DEPTH-1: return to IDLE, busy=0, clr_done=1 for one cycle, cnt=0.
  - clr_rq while in CLEAR is ignored; it does not restart the clear.
- Write (busy=0, wr_rq=1, wr_addr<DEPTH): mem[wr_addr] <= wr_data at the edge.
- Write with wr_addr>=DEPTH: no memory change; addr_err=1 next cycle.
- Read (busy=0, rd_rq=1):
  - next edge: rd_data <= mem[rd_addr], rd_valid=1 for one cycle. Latency is 1 cycle.
  - rd_addr>=DEPTH: rd_data <= 0, rd_valid=1, addr_err=1.
  - No read accepted: rd_valid=0 and rd_data holds its last value.
- Read and write to the same in-range address in the same cycle: write-first; rd_data = wr_data.
- Read and write to different addresses in the same cycle: both complete.
- While busy=1, any wr_rq or rd_rq is refused:
  - no memory change, no rd_valid;
  - req_drop=1 next cycle.
- Read accepted in the cycle clr_rq is sampled: returns the pre-clear contents.
- All pulse outputs are registered and last exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Width rules:
  - ADDR_W must satisfy 2**ADDR_W >= DEPTH; the clear counter is ADDR_W bits.
  - CLR_VAL is truncated or zero-extended to DATA_W.
- No X on any output after reset, whatever the inputs.

Decomposition:
- Shared package aes_mem_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR);
  - the default constants AES_BYTE_W=8 and AES_BUF_DEPTH=64;
  - the constant AES_BLOCK_BYTES=16, used by instantiators.
- One natural sub-module, aes_ram_clr_seq: the clear FSM plus counter. It outputs busy, clr_done, clr_we and clr_addr.
- The top-level block muxes the clear-engine write over the user write port.
- Memory array and read register stay in the top-level block.

Test Plan:
- Reset, then read addresses 0, 31 and 63 -> rd_data=0x00 with rd_valid=1 exactly one cycle after each rd_rq; addr_err=0.
- Write 0xA5 to address 10; the next cycle read address 10 -> rd_data=0xA5. Then write 0x3C and read address 10 in the same cycle -> rd_data=0x3C (bypass).
- Fill all 64 words with addr^0x5A, then pulse clr_rq with CLR_VAL=0xFF:
  - busy=1 for exactly 64 cycles, then clr_done pulses once;
  - reading any address returns 0xFF;
  - a wr_rq to address 5 during the clear -> req_drop=1, and after the clear mem[5]=0xFF.
- Assert rst mid-clear at cnt=20 -> busy=0 immediately, no clr_done, and all words read 0x00.
- DEPTH=48, ADDR_W=6: write 0x77 to address 50 -> addr_err=1 and no memory change. Read address 50 -> rd_data=0, rd_valid=1, addr_err=1.
- DATA_W=128, DEPTH=16 (AES key schedule): write round keys to 0..10 and read back in random order, including reads on the same cycle as writes to other addresses. Every read must match, with latency 1.
